serial_number_loader: RTL and testbench

Upstream feeder for the palindrome checker and the other number-analysis stages. It receives a 32-bit operand as a serial bit stream, assembles it MSB-first in a shift register, and presents it as a stable parallel word `A[31:0]` with a valid/acknowledge handshake. While presented, `A` stays constant, so the combinational analyzers downstream see a settled operand for as long as the consumer needs.

---
 rtl/serial_number_loader.sv | 133 +++++++++++++
 tb/tb_serial_number_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_number_loader.sv
// Serial-to-parallel operand loader: assembles a 32-bit word MSB-first and holds it under a valid/ack handshake.
// Optional even-parity trailer bit and err pulse are compiled in with `LOADER_PARITY_EN.
module serial_number_loader #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             din,
    input  logic             din_valid,
    input  logic             a_ack,
    output logic [WIDTH-1:0] A,
    output logic             a_valid,
    output logic             busy,
    output logic             err,
    output logic [1:0]       state_dbg
);

    // Handshake: A is valid while a_valid is high; the cycle a_ack is sampled
    // with a_valid high completes the transfer and a_valid drops on that edge.

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
`ifdef LOADER_PARITY_EN
        PARITY = 2'd2,
`endif
        HOLD   = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [WIDTH-1:0] sr, sr_n;
    logic [WIDTH-1:0] a_n;
`ifdef LOADER_PARITY_EN
    logic            err_n;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sr_n    = sr;
        a_n     = A;
`ifdef LOADER_PARITY_EN
        err_n   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    cnt_n   = '0;
                    sr_n    = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (start) begin
                    cnt_n = '0;
                    sr_n  = '0;
                end else if (din_valid) begin
                    sr_n  = {sr[WIDTH-2:0], din};
                    cnt_n = cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
`ifdef LOADER_PARITY_EN
                        state_n = PARITY;
`else
                        a_n     = {sr[WIDTH-2:0], din};
                        state_n = HOLD;
`endif
                    end
                end
            end
`ifdef LOADER_PARITY_EN
            PARITY: begin
                if (start) begin
                    cnt_n   = '0;
                    sr_n    = '0;
                    state_n = SHIFT;
                end else if (din_valid) begin
                    // Data plus trailer bit must have an even number of ones.
                    if (^{sr, din} == 1'b0) begin
                        a_n     = sr;
                        state_n = HOLD;
                    end else begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
`endif
            HOLD: begin
                if (a_ack) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            sr      <= '0;
            A       <= '0;
            a_valid <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            sr      <= sr_n;
            A       <= a_n;
            a_valid <= (state_n == HOLD);
`ifdef LOADER_PARITY_EN
            busy    <= (state_n == SHIFT) || (state_n == PARITY);
`else
            busy    <= (state_n == SHIFT);
`endif
        end
    end

`ifdef LOADER_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) err <= 1'b0;
        else     err <= err_n;
    end
`else
    assign err = 1'b0;
`endif

    assign state_dbg = state;

endmodule

// File: tb/tb_serial_number_loader.sv
// Randomized scoreboard bench for serial_number_loader; builds with or without LOADER_PARITY_EN.
module tb_serial_number_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic        a_ack = 1'b0;
    logic [31:0] A;
    logic        a_valid;
    logic        busy;
    logic        err;
    logic [1:0]  state_dbg;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int err_seen = 0;
    int err_exp = 0;
    bit mon_en = 1'b0;

    logic [31:0] exp_q[$];
    int          lat_q[$];

    serial_number_loader #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
        .a_ack(a_ack), .A(A), .a_valid(a_valid), .busy(busy), .err(err),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input bit dv);
        start = 1'b1; din_valid = dv; din = 1'b1;
        tick();
        start = 1'b0; din_valid = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        din_valid = 1'b1; din = b;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic partial(input int nbits);
        do_start(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(1'($urandom_range(0, 1)));
    endtask

    // gap_mode: 0 none, 1 every third cycle idle, 2 random idles
    task automatic load(input logic [31:0] w, input int gap_mode, input bit par_ok,
                        input bit start_dv, output bit delivered);
        int c0;
        int gaps;
        c0 = cyc;
        gaps = 0;
        do_start(start_dv);
        chk("busy_rise", {31'b0, busy}, 32'd1);
        for (int i = 31; i >= 0; i--) begin
            if (gap_mode == 1 && i != 31 && ((31 - i) % 2 == 0)) begin
                tick(); gaps++;
            end
            if (gap_mode == 2 && $urandom_range(0, 3) == 0) begin
                tick(); gaps++;
            end
            send_bit(w[i]);
        end
`ifdef LOADER_PARITY_EN
        send_bit((^w) ^ !par_ok);
        delivered = par_ok;
        if (par_ok) begin
            exp_q.push_back(w);
            lat_q.push_back(c0 + 34 + gaps);
        end else begin
            err_exp++;
            chk("err_pulse", {31'b0, err}, 32'd1);
            chk("err_no_valid", {31'b0, a_valid}, 32'd0);
            chk("err_idle_busy", {31'b0, busy}, 32'd0);
        end
`else
        delivered = 1'b1;
        exp_q.push_back(w);
        lat_q.push_back(c0 + 33 + gaps);
`endif
    endtask

    task automatic ack_after(input int hold);
        int n;
        n = 0;
        while (!a_valid && n < 100) begin
            tick(); n++;
        end
        if (!a_valid) chk("valid_timeout", 32'd0, 32'd1);
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", {31'b0, a_valid}, 32'd1);
            tick();
        end
        a_ack = 1'b1;
        tick();
        a_ack = 1'b0;
        chk("ack_drop", {31'b0, a_valid}, 32'd0);
        chk("ack_idle_busy", {31'b0, busy}, 32'd0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [31:0] a_model = 32'h0;
    bit          prev_valid = 1'b0;
    bit          prev_err = 1'b0;
    bit          rst_prev = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_prev) a_model = 32'h0;
            if (a_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", A, a_model);
                end else begin
                    a_model = exp_q.pop_front();
                    chk("a_value", A, a_model);
                    chk("a_latency", 32'(cyc), 32'(lat_q.pop_front()));
                end
            end else begin
                chk("a_stable", A, a_model);
            end
            if (err) begin
                err_seen++;
                if (prev_err) chk("err_width", 32'd2, 32'd1);
            end
            prev_valid = a_valid;
            prev_err = err;
        end
        rst_prev = rst;
    end

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_A", A, 32'h0);
        chk("rst_valid", {31'b0, a_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        mon_en = 1'b1;

        // ack with nothing presented must do nothing
        a_ack = 1'b1; tick(); a_ack = 1'b0;
        chk("idle_ack_valid", {31'b0, a_valid}, 32'd0);
        chk("idle_ack_busy", {31'b0, busy}, 32'd0);

        // din_valid in IDLE is ignored
        send_bit(1'b1); send_bit(1'b1);
        chk("idle_din_busy", {31'b0, busy}, 32'd0);

        load(32'h8000_0001, 0, 1'b1, 1'b0, ok);
        ack_after(3);

        load(32'hA5A5_5A5A, 1, 1'b1, 1'b0, ok);
        ack_after(0);

        partial(10);
        load(32'h1234_5678, 0, 1'b1, 1'b0, ok);
        ack_after(1);

        // restart whose start cycle also carries a valid bit
        partial(5);
        load(32'h0F0F_3C3C, 0, 1'b1, 1'b1, ok);
        ack_after(0);

        load(32'hFFFF_0000, 0, 1'b1, 1'b0, ok);
        ack_after(5);

        // ack together with start: returns to IDLE and start is dropped
        load(32'h55AA_00FF, 0, 1'b1, 1'b0, ok);
        tick();
        a_ack = 1'b1; start = 1'b1;
        tick();
        a_ack = 1'b0; start = 1'b0;
        chk("ackstart_valid", {31'b0, a_valid}, 32'd0);
        chk("ackstart_busy", {31'b0, busy}, 32'd0);
        send_bit(1'b1);
        chk("ackstart_ignored", {31'b0, busy}, 32'd0);

        // reset mid-frame
        partial(17);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_A", A, 32'h0);
        chk("midrst_valid", {31'b0, a_valid}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        load(32'h0000_0001, 0, 1'b1, 1'b0, ok);
        ack_after(0);

`ifdef LOADER_PARITY_EN
        load(32'h0000_0003, 0, 1'b1, 1'b0, ok);
        ack_after(0);
        load(32'h0000_0007, 0, 1'b0, 1'b0, ok);
        tick();
        chk("perr_A_kept", A, 32'h0000_0003);
        chk("perr_err_low", {31'b0, err}, 32'd0);
`endif

        for (int k = 0; k < 20; k++) begin
            load($urandom, $urandom_range(0, 2), ($urandom_range(0, 4) != 0), 1'b0, ok);
            if (ok) ack_after($urandom_range(0, 4));
            else tick();
        end

        repeat (4) tick();
        chk("queue_drain", 32'(exp_q.size()), 32'd0);
        chk("err_count", 32'(err_seen), 32'(err_exp));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
